// File: rtl/data_sram_resp.sv
// ============================================================================
// Module      : data_sram_resp
// Description : Data SRAM with byte-lane writes, registered read data,
//               out-of-range detection and optional wait states that are
//               compiled in with the DSRAM_WAIT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_sram_resp #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        addr_err
);

    logic [31:0]       r_mem [0:(1<<ADDR_W)-1];
    logic [31:0]       r_rdata;
    logic              r_addr_err;

    // The access that executes at the end of the current cycle
    logic              w_exec;
    logic [3:0]        w_ex_wen;
    logic [31:0]       w_ex_addr;
    logic [31:0]       w_ex_wdata;
    logic              w_oor;
    logic [ADDR_W-1:0] w_idx;
    logic              w_unused_lsb;

`ifdef DSRAM_WAIT_EN
    localparam logic [0:0] c_idle     = 1'b0;
    localparam logic [0:0] c_wait     = 1'b1;
    localparam logic [3:0] c_cnt_init = 4'(WAIT_CYC) - 4'd1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nx;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nx;
    logic        w_latch;
    logic [3:0]  r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_latch    = 1'b0;
        stallreq   = 1'b0;
        w_exec     = 1'b0;
        w_ex_wen   = data_sram_wen;
        w_ex_addr  = data_sram_addr;
        w_ex_wdata = data_sram_wdata;
        case (r_state)
            c_idle: begin
                if (data_sram_en) begin
                    if (WAIT_CYC == 0) begin
                        w_exec = 1'b1;
                    end else begin
                        stallreq   = 1'b1;
                        w_latch    = 1'b1;
                        w_state_nx = c_wait;
                        w_cnt_nx   = c_cnt_init;
                    end
                end
            end
            c_wait: begin
                // Inputs are ignored here; the latched request is replayed
                w_ex_wen   = r_wen;
                w_ex_addr  = r_addr;
                w_ex_wdata = r_wdata;
                if (r_cnt != 4'd0) begin
                    stallreq = 1'b1;
                    w_cnt_nx = r_cnt - 4'd1;
                end else begin
                    w_exec     = 1'b1;
                    w_state_nx = c_idle;
                end
            end
            default: w_state_nx = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_wen   <= data_sram_wen;
            r_addr  <= data_sram_addr;
            r_wdata <= data_sram_wdata;
        end
    end
`else
    logic w_unused_wait;

    assign w_unused_wait = ^(4'(WAIT_CYC));
    assign stallreq      = 1'b0;
    assign w_exec        = data_sram_en;
    assign w_ex_wen      = data_sram_wen;
    assign w_ex_addr     = data_sram_addr;
    assign w_ex_wdata    = data_sram_wdata;
`endif

    assign w_oor        = (w_ex_addr >> (ADDR_W + 2)) != 32'd0;
    assign w_idx        = w_ex_addr[ADDR_W+1:2];
    assign w_unused_lsb = ^w_ex_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata    <= 32'd0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_exec && w_oor;
            if (w_exec && (w_ex_wen == 4'd0)) begin
                r_rdata <= w_oor ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Storage is never reset; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (!rst && w_exec && !w_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (w_ex_wen[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_ex_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = r_rdata;
    assign addr_err        = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_data_sram_resp.sv
// ============================================================================
// Module      : tb_data_sram_resp
// Description : Scoreboard bench for data_sram_resp; expected wait depth
//               follows the DSRAM_WAIT_EN macro (3 stalls when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_sram_resp;

`ifdef DSRAM_WAIT_EN
    localparam int N = 3;
`else
    localparam int N = 0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stallreq;
    logic        addr_err;

    data_sram_resp #(.ADDR_W(10), .WAIT_CYC(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .stallreq        (stallreq),
        .addr_err        (addr_err)
    );

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
        string       nm;
    } item_t;

    item_t       q[$];
    logic [31:0] mem_m [0:1023];
    logic [31:0] m_rd;
    logic        stall_exp [0:4095];
    int          cyc;
    int          chk_cnt;
    int          pass_cnt;
    logic        mon_on;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        else pass_cnt++;
    endtask

    // Monitor: compares outputs against whatever is due this cycle
    always @(negedge clk) begin
        if (mon_on) begin
            logic  exp_err;
            item_t it;
            exp_err = 1'b0;
            chk("stallreq", {31'd0, stallreq}, {31'd0, stall_exp[cyc]});
            while (q.size() > 0 && q[0].cyc < cyc) begin
                it = q.pop_front();
                chk_cnt++;
                $display("FAIL %s: response due at cycle %0d not observed, now %0d", it.nm, it.cyc, cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                it = q.pop_front();
                chk(it.nm, rdata, it.rd);
                exp_err = it.err;
            end
            chk("addr_err", {31'd0, addr_err}, {31'd0, exp_err});
        end
    end

    function automatic void push(input int c, input logic [31:0] rd, input logic err, input string nm);
        item_t it;
        it.cyc = c;
        it.rd  = rd;
        it.err = err;
        it.nm  = nm;
        q.push_back(it);
    endfunction

    task automatic junk();
        en    = 1'b1;
        wen   = 4'hF;
        addr  = 32'h40;
        wdata = 32'hDEAD_BEEF;
    endtask

    task automatic access(input string nm, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        int   t;
        logic oor;
        t     = cyc;
        oor   = a[31:12] != 20'd0;
        en    = 1'b1;
        wen   = w;
        addr  = a;
        wdata = d;
        if (w == 4'd0) begin
            m_rd = oor ? 32'd0 : mem_m[a[11:2]];
        end else if (!oor) begin
            for (int i = 0; i < 4; i++)
                if (w[i]) mem_m[a[11:2]][8*i +: 8] = d[8*i +: 8];
        end
        push(t + N + 1, m_rd, oor, nm);
        for (int k = 0; k < N; k++) stall_exp[t + k] = 1'b1;
        repeat (N) begin
            @(posedge clk); #1;
            junk();
        end
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            en = 1'b0;
            push(cyc + 1, m_rd, 1'b0, "idle_hold");
            @(posedge clk); #1;
        end
    endtask

    // Write accepted, then reset one cycle later
    task automatic rst_mid(input logic [31:0] a, input logic [31:0] d);
        int t;
        t     = cyc;
        en    = 1'b1;
        wen   = 4'hF;
        addr  = a;
        wdata = d;
        if (N == 0) begin
            mem_m[a[11:2]] = d;
            push(t + 1, m_rd, 1'b0, "pre_rst_write");
        end
        for (int k = 0; k < N && k < 2; k++) stall_exp[t + k] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        junk();
        @(posedge clk); #1;
        rst  = 1'b0;
        en   = 1'b0;
        m_rd = 32'd0;
        push(t + 2, 32'd0, 1'b0, "after_rst");
    endtask

    initial begin
        cyc      = 0;
        chk_cnt  = 0;
        pass_cnt = 0;
        mon_on   = 1'b0;
        m_rd     = 32'd0;
        for (int i = 0; i < 4096; i++) stall_exp[i] = 1'b0;
        rst   = 1'b1;
        en    = 1'b0;
        wen   = 4'd0;
        addr  = 32'd0;
        wdata = 32'd0;
        @(posedge clk); #1;
        mon_on = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        push(cyc, 32'd0, 1'b0, "reset_state");
        idle(1);

        access("wr_10",      4'hF,    32'h10,   32'h1234_5678);
        access("rd_10",      4'h0,    32'h10,   32'h0);
        idle(1);
        access("wr_20_full", 4'hF,    32'h20,   32'hAABB_CCDD);
        access("wr_20_lane", 4'b0101, 32'h20,   32'h1122_3344);
        access("rd_20",      4'h0,    32'h20,   32'h0);
        access("wr_0",       4'hF,    32'h0,    32'hCAFE_F00D);
        access("wr_40",      4'hF,    32'h40,   32'h5566_7788);
        access("rd_oor",     4'h0,    32'h1000, 32'h0);
        access("wr_oor",     4'hF,    32'h1000, 32'hFFFF_FFFF);
        access("rd_0",       4'h0,    32'h0,    32'h0);
        idle(2);

        rst_mid(32'h20, 32'h9999_9999);
        access("rd_20_rst",  4'h0,    32'h20,   32'h0);

        access("b2b_rd_10",  4'h0,    32'h10,   32'h0);
        access("b2b_rd_20",  4'h0,    32'h20,   32'h0);
        access("rd_40",      4'h0,    32'h40,   32'h0);
        idle(3);

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        while (q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            chk_cnt++;
            $display("FAIL %s: response due at cycle %0d never checked", it.nm, it.cyc);
        end
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", chk_cnt);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; storage is 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYC, default 0, range 0..15, stall cycles inserted per access (used only when DSRAM_WAIT_EN is defined).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_sram_en  input  1  access request from the MEM-side initiator.
REQ-006 data_sram_wen  input  4  byte write enables; 0 means read.
REQ-007 data_sram_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 data_sram_wdata  input  32  write data, byte lane i = bits [8i+7:8i].
REQ-009 data_sram_rdata  output  32  registered read data.
REQ-010 stallreq  output  1  combinational stall request to the pipeline controller.
REQ-011 addr_err  output  1  registered one-cycle flag for an out-of-range access.

Function
REQ-012 Word index = addr[ADDR_W+1:2]; an address is out of range when addr[31:ADDR_W+2] is nonzero.
REQ-013 FSM states: IDLE and WAIT, plus a 4-bit down-counter cnt.
REQ-014 Accept occurs in IDLE with en=1; addr, wen and wdata are latched at accept, and the initiator may change them afterwards.
REQ-015 WAIT_CYC=0: the access executes at the edge ending the accept cycle T; rdata is valid in T+1; stallreq stays 0; the FSM stays in IDLE.
REQ-016 WAIT_CYC=N>0, IDLE accept: stallreq=1 in cycle T; next state WAIT with cnt=N-1.
REQ-017 WAIT with cnt!=0: stallreq=1; cnt decrements.
REQ-018 WAIT with cnt==0: stallreq=0; the latched access executes at the end of this cycle; next state IDLE.
REQ-019 Net effect for N>0: stallreq is high for exactly N cycles (T..T+N-1); rdata is valid in T+N+1.
REQ-020 Inputs are ignored while in WAIT; no second accept occurs until IDLE.
REQ-021 A request presented in the cycle right after WAIT->IDLE is accepted normally, so back-to-back accesses each incur N stall cycles.
REQ-022 Read (wen=0): rdata <= mem[index].
REQ-023 Write (wen!=0): for each i with wen[i]=1, mem[index] lane i <= wdata lane i; other lanes are unchanged; rdata holds its previous value.
REQ-024 en=0 in IDLE: no access; rdata holds; addr_err <= 0.
REQ-025 Out-of-range access: the write is suppressed; a read sets rdata <= 0; addr_err=1 for exactly the cycle rdata would be valid.
REQ-026 addr_err is 0 in every other cycle.
REQ-027 A read immediately after a write to the same word returns the newly written bytes.

Reset
REQ-028 On rst=1 at a clock edge: state <= IDLE, cnt <= 0, rdata <= 0, addr_err <= 0; stallreq reads 0 in the following cycle.
REQ-029 Reset during WAIT drops the pending access; no write occurs.
REQ-030 Memory contents are not reset.
REQ-031 rst has priority over every other event in the same cycle.

Configuration
REQ-032 Macro DSRAM_WAIT_EN defined: the wait-state FSM and WAIT_CYC are compiled in, per REQ-016..REQ-021.
REQ-033 Macro DSRAM_WAIT_EN undefined: WAIT state, counter and latches are absent; WAIT_CYC is ignored; behaviour is always per REQ-015; stallreq is tied to 0.

Verification
REQ-034 WAIT_CYC=0: write 0x12345678 to addr 0x10 with wen=4'hF, then read 0x10 -> rdata=0x12345678 in the cycle after the read; stallreq is 0 throughout.
REQ-035 Byte enables: word 0x20 holds 0xAABBCCDD; write wdata=0x11223344 with wen=4'b0101, then read -> rdata=0xAA22CC44.
REQ-036 WAIT_CYC=3 (DSRAM_WAIT_EN defined): read accepted at cycle T -> stallreq high in T..T+2, low in T+3, rdata valid in T+4; addr changed in T+1 has no effect.
REQ-037 Out of range, ADDR_W=10: read addr 0x0000_1000 -> rdata=0 and addr_err=1 for one cycle; a write to the same address leaves word 0 unchanged.
REQ-038 Reset mid-wait, WAIT_CYC=3: write accepted, rst asserted in T+1 -> stallreq=0 after reset; the target word still holds its old value.
REQ-039 Back-to-back, WAIT_CYC=2: two reads presented consecutively -> two separate 2-cycle stallreq pulses with one low cycle between them; both rdata values are correct.
